// File: rtl/uc_movimento_elevador.sv
// Movement sequencer for the SmartCargo elevator: serves the head of the floor queue,
// steps the car one floor at a time, holds the door open and pops the served entry.
module uc_movimento_elevador #(
   parameter int unsigned N_ANDARES = 8,
   parameter int unsigned W_ANDAR   = 3,
   parameter int unsigned T_ANDAR   = 50,
   parameter int unsigned T_PORTA   = 100
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   input  logic               fila_vazia,
   input  logic [W_ANDAR-1:0] andar_alvo,
   input  logic               ram_ocupada,
   output logic [W_ANDAR-1:0] andar_atual,
   output logic               sobe,
   output logic               desce,
   output logic               porta_aberta,
   output logic               remove_topo,
   output logic               em_servico,
   output logic [3:0]         Eatual_db
);

   localparam int unsigned T_MAX = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
   localparam int unsigned W_T   = $clog2(T_MAX);

   localparam logic [W_T-1:0]     FIM_ANDAR = W_T'(T_ANDAR - 1);
   localparam logic [W_T-1:0]     FIM_PORTA = W_T'(T_PORTA - 1);
   localparam logic [W_ANDAR-1:0] TOPO      = W_ANDAR'(N_ANDARES - 1);

   typedef enum logic [3:0] {
      INICIAL    = 4'd0,
      ESPERA     = 4'd1,
      COMPARA    = 4'd2,
      SOBE       = 4'd3,
      DESCE      = 4'd4,
      PORTA      = 4'd5,
      REMOVE     = 4'd6,
      POS_REMOVE = 4'd7
   } state_t;

   state_t             state, next_state;
   logic [W_T-1:0]     timer, next_timer;
   logic [W_ANDAR-1:0] next_andar;
   logic               alvo_invalido;

   assign alvo_invalido = (32'(andar_alvo) >= N_ANDARES);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= INICIAL;
         timer       <= '0;
         andar_atual <= '0;
      end else begin
         state       <= next_state;
         timer       <= next_timer;
         andar_atual <= next_andar;
      end
   end

   always_comb begin
      next_state = state;
      next_timer = '0;
      next_andar = andar_atual;
      unique case (state)
         INICIAL: if (iniciar) next_state = ESPERA;
         ESPERA:  if (!fila_vazia) next_state = COMPARA;
         COMPARA: begin
            if (fila_vazia)                     next_state = ESPERA;
            else if (alvo_invalido)             next_state = REMOVE;
            else if (andar_alvo == andar_atual) next_state = PORTA;
            else if (andar_alvo > andar_atual)  next_state = SOBE;
            else                                next_state = DESCE;
         end
         SOBE: begin
            if (timer == FIM_ANDAR) begin
               next_state = COMPARA;
               if (andar_atual != TOPO) next_andar = andar_atual + 1'b1;
            end else begin
               next_timer = timer + 1'b1;
            end
         end
         DESCE: begin
            if (timer == FIM_ANDAR) begin
               next_state = COMPARA;
               if (andar_atual != '0) next_andar = andar_atual - 1'b1;
            end else begin
               next_timer = timer + 1'b1;
            end
         end
         PORTA: begin
            if (timer == FIM_PORTA) next_state = REMOVE;
            else                    next_timer = timer + 1'b1;
         end
         REMOVE:     if (!ram_ocupada) next_state = POS_REMOVE;
         POS_REMOVE: next_state = ESPERA;
         default:    next_state = INICIAL;
      endcase
   end

   assign sobe         = (state == SOBE);
   assign desce        = (state == DESCE);
   assign porta_aberta = (state == PORTA);
   // The pop strobe is qualified in-cycle by ram_ocupada so it fires on the exact cycle REMOVE leaves.
   assign remove_topo  = (state == REMOVE) && !ram_ocupada;
   assign em_servico   = (state != INICIAL) && (state != ESPERA);
   assign Eatual_db    = state;

endmodule

// File: tb/tb_uc_movimento_elevador.sv
// Scoreboard bench for uc_movimento_elevador: the driver acts as the queue RAM and pushes the
// expected floor/door/pop events; a negedge monitor pops and compares them as the DUT produces them.
module tb_uc_movimento_elevador;

   localparam int unsigned N  = 6;
   localparam int unsigned W  = 3;
   localparam int unsigned TA = 4;
   localparam int unsigned TP = 6;
   localparam int LIMITE = 2000;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         iniciar = 1'b0;
   logic         fila_vazia = 1'b1;
   logic         ram_ocupada = 1'b0;
   logic [W-1:0] andar_alvo = '0;
   logic [W-1:0] andar_atual;
   logic         sobe, desce, porta_aberta, remove_topo, em_servico;
   logic [3:0]   Eatual_db;

   typedef enum int {EV_SOBE, EV_DESCE, EV_PORTA, EV_POP} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       valor;
      int       aux;
   } ev_t;

   ev_t esperado[$];
   int  fila[$];
   int  modelo_andar = 0;
   int  tests = 0;
   int  fails = 0;

   always #5 clock = ~clock;

   uc_movimento_elevador #(
      .N_ANDARES(N), .W_ANDAR(W), .T_ANDAR(TA), .T_PORTA(TP)
   ) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .fila_vazia(fila_vazia),
      .andar_alvo(andar_alvo), .ram_ocupada(ram_ocupada), .andar_atual(andar_atual),
      .sobe(sobe), .desce(desce), .porta_aberta(porta_aberta), .remove_topo(remove_topo),
      .em_servico(em_servico), .Eatual_db(Eatual_db)
   );

   // ---------------- monitor ----------------
   int   up_run = 0, dn_run = 0, porta_run = 0, rem_run = 0, prev_andar = 0;
   logic prev_porta = 1'b0;

   task automatic confere(input ev_kind_t k, input int valor, input int aux, input string nome);
      ev_t e;
      tests++;
      if (esperado.size() == 0) begin
         fails++;
         $display("FAIL %s: unexpected event kind=%0d floor=%0d aux=%0d, required no event", nome, k, valor, aux);
      end else begin
         e = esperado.pop_front();
         if (e.kind != k || e.valor != valor || e.aux != aux) begin
            fails++;
            $display("FAIL %s: got kind=%0d floor=%0d aux=%0d, required kind=%0d floor=%0d aux=%0d",
                     nome, k, valor, aux, e.kind, e.valor, e.aux);
         end
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         up_run = 0; dn_run = 0; porta_run = 0; rem_run = 0;
         prev_andar = 0; prev_porta = 1'b0;
      end else begin
         tests++;
         if ((sobe && desce) || (porta_aberta && (sobe || desce))) begin
            fails++;
            $display("FAIL exclusive: sobe=%0b desce=%0b porta=%0b, required at most one", sobe, desce, porta_aberta);
         end
         if (int'(andar_atual) > prev_andar)
            confere(EV_SOBE, int'(andar_atual), up_run, "andar_sobe");
         else if (int'(andar_atual) < prev_andar)
            confere(EV_DESCE, int'(andar_atual), dn_run, "andar_desce");
         if (prev_porta && !porta_aberta)
            confere(EV_PORTA, int'(andar_atual), porta_run, "porta");
         if (remove_topo)
            confere(EV_POP, (Eatual_db == 4'd6) ? int'(andar_atual) : -1, rem_run, "pop");
         up_run    = sobe ? up_run + 1 : 0;
         dn_run    = desce ? dn_run + 1 : 0;
         porta_run = porta_aberta ? porta_run + 1 : 0;
         rem_run   = (Eatual_db == 4'd6 && !remove_topo) ? rem_run + 1 : 0;
         prev_andar = int'(andar_atual);
         prev_porta = porta_aberta;
      end
   end

   // ---------------- driver / queue RAM model ----------------
   task automatic espera_ciclo;
      @(posedge clock);
      #1;
   endtask

   task automatic atualiza_fila;
      fila_vazia = (fila.size() == 0);
      andar_alvo = (fila.size() != 0) ? W'(fila[0]) : '0;
   endtask

   task automatic checa(input string nome, input int got, input int req);
      tests++;
      if (got != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", nome, got, req);
      end
   endtask

   // Serve one entry; k = cycles the insertion path keeps the RAM busy once REMOVE is reached.
   task automatic atender(input int alvo, input int k);
      int n;
      if (alvo >= int'(N)) begin
         esperado.push_back('{EV_POP, modelo_andar, k});
      end else begin
         while (modelo_andar != alvo) begin
            if (alvo > modelo_andar) begin
               modelo_andar++;
               esperado.push_back('{EV_SOBE, modelo_andar, int'(TA)});
            end else begin
               modelo_andar--;
               esperado.push_back('{EV_DESCE, modelo_andar, int'(TA)});
            end
         end
         esperado.push_back('{EV_PORTA, modelo_andar, int'(TP)});
         esperado.push_back('{EV_POP, modelo_andar, k});
      end
      fila.push_back(alvo);
      atualiza_fila();
      ram_ocupada = (k > 0);
      n = 0;
      while (Eatual_db != 4'd6 && n < LIMITE) begin
         espera_ciclo();
         n++;
      end
      if (n >= LIMITE) begin
         tests++; fails++;
         $display("FAIL timeout_remove: target %0d never reached REMOVE, required within %0d cycles", alvo, LIMITE);
         ram_ocupada = 1'b0;
         fila.delete();
         atualiza_fila();
         return;
      end
      repeat (k) espera_ciclo();
      ram_ocupada = 1'b0;
      espera_ciclo();
      void'(fila.pop_front());
      atualiza_fila();
   endtask

   initial begin
      int n;
      int alvo;
      repeat (3) espera_ciclo();
      @(negedge clock);
      checa("reset_values", int'({Eatual_db, andar_atual, sobe, desce, porta_aberta, remove_topo, em_servico}), 0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) espera_ciclo();
      checa("inicial_hold", int'(Eatual_db), 0);

      // reset in the middle of an upward trip
      iniciar = 1'b1;
      fila.push_back(5);
      atualiza_fila();
      n = 0;
      while (!sobe && n < LIMITE) begin
         espera_ciclo();
         n++;
      end
      checa("reach_sobe", int'(sobe), 1);
      espera_ciclo();
      reset = 1'b0;
      @(negedge clock);
      checa("reset_mid_sobe", int'({Eatual_db, andar_atual, sobe, remove_topo, em_servico}), 0);
      fila.delete();
      atualiza_fila();
      esperado.delete();
      modelo_andar = 0;
      @(posedge clock); #1;
      reset = 1'b1;

      // directed trips
      atender(3, 0);
      atender(5, 3);
      atender(2, 10);
      atender(4, 0);
      atender(4, 2);
      atender(7, 0);
      atender(6, 4);

      // service must continue with iniciar low
      iniciar = 1'b0;
      for (int i = 0; i < 14; i++) begin
         alvo = int'($urandom_range(0, 7));
         atender(alvo, int'($urandom_range(0, 10)));
      end

      repeat (4) espera_ciclo();
      checa("scoreboard_drained", esperado.size(), 0);
      checa("final_floor", int'(andar_atual), modelo_andar);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
